// File: rtl/dcache_assoc.sv
// dcache_assoc: write-back, write-allocate L1 data cache, 1- or 2-way set
// associative with LRU replacement, between a 16-bit load/store client and a
// narrow serial memory port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   paddr [PA-1:1]    halfword address of the request
//   read, write       01 low byte, 10 high byte, 11 halfword, 00 none
//   wdata             store data (byte stores take wdata[7:0])
//   fault             MMU fault: request ignored while set (IDLE only)
//   flush_all         one-cycle invalidate of the whole cache, aborts memory traffic
//   flush_write       with a request: write back the line if dirty, then invalidate it
//   done, rdata       request completion and load data (byte loads zero-extended)
//   mem_req/mem_we    memory transaction active / 1 = writeback, 0 = fill
//   mem_addr          line address of the transaction
//   mem_wdata/rdata   writeback / fill beat, one per mem_strobe
//
// Optional build macro DCACHE_STATS_EN adds saturating hit_count/miss_count
// outputs.
//
// Beats move bytes in ascending order; with BUS=4 the high nibble of each
// byte goes first. Index and offset fields are taken from the byte address
// {paddr, 1'b0}. NSETS is assumed to be at least 2.

module dcache_assoc #(
  parameter int LINE_LENGTH = 4,
  parameter int NSETS       = 4,
  parameter int NWAYS       = 2,
  parameter int RV          = 16,
  parameter int PA          = 22,
  parameter int BUS         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PA-1:1]                     paddr,
  input  logic [1:0]                        read,
  input  logic [1:0]                        write,
  input  logic [RV-1:0]                     wdata,
  input  logic                              fault,
  input  logic                              flush_all,
  input  logic                              flush_write,
  output logic                              done,
  output logic [RV-1:0]                     rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [PA-$clog2(LINE_LENGTH)-1:0] mem_addr,
  output logic [BUS-1:0]                    mem_wdata,
  input  logic [BUS-1:0]                    mem_rdata,
  input  logic                              mem_strobe
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count
`endif
);

  localparam int OB    = $clog2(LINE_LENGTH);
  localparam int IB    = $clog2(NSETS);
  localparam int TB    = PA - OB - IB;
  localparam int BEATS = LINE_LENGTH * 8 / BUS;
  localparam int CW    = $clog2(BEATS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  // Request decode
  logic [PA-1:0] ba;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [OB-1:0] off0, off1;
  logic          req, is_wr;

  assign ba    = {paddr, 1'b0};
  assign idx   = ba[OB+IB-1:OB];
  assign tag   = ba[PA-1:OB+IB];
  assign off0  = ba[OB-1:0];
  assign off1  = off0 | OB'(1);
  assign req   = (|read) || (|write);
  assign is_wr = |write;           // write wins if both are set

  // State
  logic [1:0]                     state;
  logic [CW-1:0]                  cnt;
  logic                           vway;      // way under WB/FILL
  logic                           wb_flush;  // WB was started by flush_write: no fill after
  logic [NWAYS-1:0][NSETS-1:0]    valid, dirty;
  logic [TB-1:0]                  tag_arr [NWAYS][NSETS];
  logic [7:0]                     data    [NWAYS][NSETS][LINE_LENGTH];

  // Lookup
  logic [NWAYS-1:0] hit_vec;
  logic             hit, hit_way, hit_dirty, victim;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < NWAYS; w++)
      hit_vec[w] = valid[w][idx] && (tag_arr[w][idx] == tag);
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_way = 1'b0;
    if (NWAYS > 1 && !hit_vec[0]) hit_way = 1'b1;
  end

  assign hit_dirty = dirty[hit_way][idx];

  // A request is only considered in IDLE, unfaulted, and outside reset/flush_all.
  logic idle_go, wr_hit, fill_beat, last_beat;

  assign idle_go   = (state == S_IDLE) && req && !fault && !flush_all && !reset;
  assign wr_hit    = idle_go && !flush_write && hit && is_wr;
  assign fill_beat = (state == S_FILL) && mem_strobe && !flush_all && !reset;
  assign last_beat = (cnt == CW'(BEATS - 1));

  // A dirty flush hit completes only after its writeback, on the next IDLE
  // cycle when the line has turned clean.
  always_comb begin
    done = 1'b0;
    if (idle_go) done = flush_write ? !(hit && hit_dirty) : hit;
  end

  // Load data
  logic [7:0] rb0, rb1;
  assign rb0 = data[hit_way][idx][off0];
  assign rb1 = data[hit_way][idx][off1];

  always_comb begin
    rdata = '0;
    case (read)
      2'b11:   rdata = RV'({rb1, rb0});
      2'b01:   rdata = RV'(rb0);
      2'b10:   rdata = RV'(rb1);
      default: rdata = '0;
    endcase
  end

  // Replacement: first invalid way, else the way the LRU bit points at.
  generate
    if (NWAYS > 1) begin : g_lru
      logic [NSETS-1:0] lru;

      always_ff @(posedge clk) begin
        if (reset || flush_all)
          lru <= '0;
        else if (idle_go && !flush_write && hit)
          lru[idx] <= ~hit_way;
      end

      assign victim = !valid[0][idx] ? 1'b0 :
                      !valid[1][idx] ? 1'b1 : lru[idx];
    end else begin : g_dm
      assign victim = 1'b0;
    end
  endgenerate

  // Beat position within the line
  logic [OB-1:0] beat_byte;
  logic [2:0]    beat_sh;

  generate
    if (BUS == 4) begin : g_nib
      assign beat_byte = cnt[CW-1:1];
      assign beat_sh   = cnt[0] ? 3'd0 : 3'd4;   // high nibble first
    end else begin : g_byte
      assign beat_byte = cnt;
      assign beat_sh   = 3'd0;
    end
  endgenerate

  // Memory port
  assign mem_req   = (state != S_IDLE);
  assign mem_we    = (state == S_WB);
  assign mem_wdata = data[vway][idx][beat_byte][beat_sh +: BUS];

  always_comb begin
    mem_addr = ba[PA-1:OB];
    if (state == S_WB) mem_addr = {tag_arr[vway][idx], idx};
  end

  // Control FSM and line status bits
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      state    <= S_IDLE;
      cnt      <= '0;
      valid    <= '0;
      dirty    <= '0;
      vway     <= 1'b0;
      wb_flush <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (idle_go) begin
          if (flush_write) begin
            if (hit && hit_dirty) begin
              state    <= S_WB;
              vway     <= hit_way;
              wb_flush <= 1'b1;
              cnt      <= '0;
            end else if (hit) begin
              valid[hit_way][idx] <= 1'b0;
            end
          end else if (hit) begin
            if (is_wr) dirty[hit_way][idx] <= 1'b1;
          end else begin
            vway     <= victim;
            wb_flush <= 1'b0;
            cnt      <= '0;
            if (valid[victim][idx] && dirty[victim][idx]) begin
              state <= S_WB;
            end else begin
              state               <= S_FILL;
              valid[victim][idx]  <= 1'b0;   // line is being overwritten
            end
          end
        end
        S_WB: if (mem_strobe) begin
          cnt <= cnt + 1'b1;                 // wraps to 0 on the last beat
          if (last_beat) begin
            dirty[vway][idx] <= 1'b0;
            if (wb_flush) begin
              state <= S_IDLE;
            end else begin
              state            <= S_FILL;
              valid[vway][idx] <= 1'b0;
            end
          end
        end
        S_FILL: if (mem_strobe) begin
          cnt <= cnt + 1'b1;
          if (last_beat) begin
            valid[vway][idx] <= 1'b1;
            dirty[vway][idx] <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays (no reset; guarded by the valid bits)
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (write[0]) data[hit_way][idx][off0] <= wdata[7:0];
      if (write == 2'b11)
        data[hit_way][idx][off1] <= wdata[15:8];
      else if (write[1])
        data[hit_way][idx][off1] <= wdata[7:0];
    end
    if (fill_beat) begin
      data[vway][idx][beat_byte][beat_sh +: BUS] <= mem_rdata;
      if (last_beat) tag_arr[vway][idx] <= tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // A non-flush request that had to go to memory first counts as a miss
  // when it finally completes.
  logic pend_miss;

  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      hit_count  <= '0;
      miss_count <= '0;
      pend_miss  <= 1'b0;
    end else begin
      if (idle_go && !flush_write && !hit) pend_miss <= 1'b1;
      if (done && !flush_write) begin
        pend_miss <= 1'b0;
        if (pend_miss) begin
          if (~&miss_count) miss_count <= miss_count + 16'd1;
        end else begin
          if (~&hit_count) hit_count <= hit_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (default parameters). Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well before the next
// rising edge. A small responder task plays the memory side of each transfer.

module tb_dcache_assoc;

  localparam int PA = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [PA-1:1] paddr;
  logic [1:0]    read, write;
  logic [15:0]   wdata;
  logic          fault, flush_all, flush_write;
  logic          done;
  logic [15:0]   rdata;
  logic          mem_req, mem_we;
  logic [19:0]   mem_addr;
  logic [3:0]    mem_wdata, mem_rdata;
  logic          mem_strobe;
`ifdef DCACHE_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif

  dcache_assoc dut (
    .clk(clk), .reset(reset), .paddr(paddr), .read(read), .write(write),
    .wdata(wdata), .fault(fault), .flush_all(flush_all), .flush_write(flush_write),
    .done(done), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_strobe(mem_strobe)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a memory transaction, check its kind and address,
  // then deliver n beats from nibs (first beat in the top nibble). For a
  // writeback the outgoing beat is compared against the same nibble.
  task automatic serve(input string tag, input logic we, input logic [19:0] addr,
                       input logic [31:0] nibs, input int n);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_req && w < 10);
    #1;
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    if (!mem_req) return;
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      mem_strobe = 1'b1;
      mem_rdata  = nibs[31-4*i -: 4];
      #1;
      if (we) chk({tag, "_wbeat"}, 32'(mem_wdata), 32'(nibs[31-4*i -: 4]));
    end
    @(negedge clk);
    mem_strobe = 1'b0;
    mem_rdata  = '0;
    #1;
  endtask

  // Drive a request on the next falling edge and let it settle.
  task automatic drive(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [20:0] a, input logic [15:0] wd);
    @(negedge clk);
    read  = rd;
    write = wr;
    paddr = a;
    wdata = wd;
    #1;
  endtask

  initial begin
    reset = 1'b1; paddr = '0; read = 2'b00; write = 2'b00; wdata = '0;
    fault = 1'b0; flush_all = 1'b0; flush_write = 1'b0;
    mem_rdata = '0; mem_strobe = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req",  32'(mem_req), 32'd0);
    chk("rst_we",   32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: cold miss fill, then hits in both halves of the line
    drive(2'b11, 2'b00, 21'h100, 16'h0);
    chk("t1_miss_done", 32'(done), 32'd0);
    serve("t1_fill", 1'b0, 20'h00080, 32'h3412_7856, 8);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'h1234);
    drive(2'b11, 2'b00, 21'h101, 16'h0);
    chk("t1_done2", 32'(done), 32'd1);
    chk("t1_rdata2", 32'(rdata), 32'h5678);

    // 2: write hit, read back, byte loads
    drive(2'b00, 2'b11, 21'h101, 16'hBEEF);
    chk("t2_wr_done", 32'(done), 32'd1);
    chk("t2_wr_req", 32'(mem_req), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("t2_hits", 32'(hit_count), 32'd1);
    chk("t2_miss", 32'(miss_count), 32'd1);
`endif
    drive(2'b11, 2'b00, 21'h101, 16'h0);
    chk("t2_rd", 32'(rdata), 32'hBEEF);
    drive(2'b10, 2'b00, 21'h100, 16'h0);
    chk("t2_rd_hi_done", 32'(done), 32'd1);
    chk("t2_rd_hi", 32'(rdata), 32'h0012);
    drive(2'b01, 2'b00, 21'h100, 16'h0);
    chk("t2_rd_lo", 32'(rdata), 32'h0034);

    // 3: second way fills clean; third tag evicts dirty LRU way 0
    drive(2'b11, 2'b00, 21'h108, 16'h0);
    chk("t3_miss1", 32'(done), 32'd0);
    serve("t3_fill1", 1'b0, 20'h00084, 32'hABCD_1234, 8);
    chk("t3_rd1", 32'(rdata), 32'hCDAB);
    drive(2'b11, 2'b00, 21'h110, 16'h0);
    chk("t3_miss2", 32'(done), 32'd0);
    serve("t3_wb", 1'b1, 20'h00080, 32'h3412_EFBE, 8);
    serve("t3_fill2", 1'b0, 20'h00088, 32'h5566_7788, 8);
    chk("t3_done2", 32'(done), 32'd1);
    chk("t3_rd2", 32'(rdata), 32'h6655);
    drive(2'b11, 2'b00, 21'h108, 16'h0);
    chk("t3_way1_kept", 32'(rdata), 32'hCDAB);

    // 5: faulted store has no effect
    @(negedge clk);
    read = 2'b00; write = 2'b11; paddr = 21'h108; wdata = 16'h1111; fault = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    fault = 1'b0; write = 2'b00; read = 2'b11;
    #1;
    chk("t5_rd", 32'(rdata), 32'hCDAB);
    // clean line: flush_write completes at once without writeback
    @(negedge clk);
    flush_write = 1'b1;
    #1;
    chk("t5_flush_clean", 32'(done), 32'd1);
    @(negedge clk);
    flush_write = 1'b0; read = 2'b00;
    #1;
    chk("t5_flush_noreq", 32'(mem_req), 32'd0);

    // 4: flush_write on a dirty hit writes back, then completes
    drive(2'b00, 2'b11, 21'h110, 16'hA5C3);
    chk("t4_wr", 32'(done), 32'd1);
    @(negedge clk);
    write = 2'b00; read = 2'b11; flush_write = 1'b1;
    #1;
    chk("t4_flush_wait", 32'(done), 32'd0);
    serve("t4_wb", 1'b1, 20'h00088, 32'hC3A5_7788, 8);
    chk("t4_flush_done", 32'(done), 32'd1);
    @(negedge clk);
    flush_write = 1'b0;
    #1;
    chk("t4_reread_miss", 32'(done), 32'd0);

    // 6a: flush_all three beats into the refill
    serve("t6_fill", 1'b0, 20'h00088, 32'h1230_0000, 3);
    flush_all = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_fa_req", 32'(mem_req), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("t6_fa_hits", 32'(hit_count), 32'd0);
    chk("t6_fa_miss", 32'(miss_count), 32'd0);
`endif
    flush_all = 1'b0;
    #1;
    chk("t6_fa_miss_again", 32'(done), 32'd0);
    serve("t6_refill", 1'b0, 20'h00088, 32'h0123_4567, 8);
    chk("t6_refill_rd", 32'(rdata), 32'h2301);

    // 6b: reset three beats into a fill
    drive(2'b11, 2'b00, 21'h108, 16'h0);
    serve("t6_rfill", 1'b0, 20'h00084, 32'h9ABC_0000, 3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_rst_miss", 32'(done), 32'd0);
    serve("t6_rst_refill", 1'b0, 20'h00084, 32'h9ABC_DEF0, 8);
    chk("t6_rst_rd", 32'(rdata), 32'hBC9A);

    @(negedge clk);
    read = 2'b00;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Next-generation L1 data cache: write-back, write-allocate, parametrised set count and line length, 1- or 2-way set associative with LRU replacement. Sits between the load/store unit (RV-bit byte/halfword accesses) and the narrow serial memory port (BUS-bit beats). An explicit writeback/fill state machine owns the memory port, so the client only holds its request until done.

Parameters:
LINE_LENGTH, 4, line size in bytes (power of 2, >=2)
NSETS, 4, number of sets (power of 2)
NWAYS, 2, associativity (1 or 2)
RV, 16, client data width
PA, 22, physical address width
BUS, 4, memory beat width in bits (4 or 8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
paddr  in  PA-1  halfword address [PA-1:1]
read  in  2  01 low byte, 10 high byte, 11 halfword, 00 none
write  in  2  same encoding as read
wdata  in  RV  store data (byte stores use wdata[7:0])
fault  in  1  MMU fault; request is suppressed
flush_all  in  1  invalidate every line without writeback
flush_write  in  1  with read/write nonzero: write back if dirty, then invalidate the addressed line
done  out  1  request complete this cycle
rdata  out  RV  load data, valid when done && |read; byte loads zero-extended
mem_req  out  1  memory transaction active
mem_we  out  1  1 = writeback, 0 = fill
mem_addr  out  PA-log2(LINE_LENGTH)  line address
mem_wdata  out  BUS  writeback beat
mem_rdata  in  BUS  fill beat
mem_strobe  in  1  one beat transferred this cycle

Behaviour:
- Reset: state IDLE, all valid/dirty/LRU bits 0, beat counter 0. done=0, mem_req=0, mem_we=0. rdata and mem_wdata undefined.
- Index = paddr[log2(LINE_LENGTH*NSETS)-1:log2(LINE_LENGTH)]; tag = paddr[PA-1:log2(LINE_LENGTH*NSETS)].
- IDLE, request (|read or |write), !fault:
  - Hit is combinational; done=1 in the same cycle.
  - Read: rdata is combinational.
  - Write: byte lanes update on that clk edge; the line becomes dirty.
  - Either hit sets the set's LRU bit to point at the other way.
- Miss: victim = lowest-index invalid way, else the LRU way. Victim dirty -> WB; clean -> FILL.
- WB: mem_req=1, mem_we=1, mem_addr = victim tag:index. Counter advances on mem_strobe. After LINE_LENGTH*8/BUS beats, clear dirty and go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr = request line. Each beat is written on mem_strobe. On the last beat: write tag, set valid, clear dirty, return to IDLE. The request then hits on the next cycle, so miss latency = beats(+WB beats)+1.
- Beat order: bytes ascending. When BUS=4, the high nibble of each byte goes first.
- fault is sampled only in IDLE. With fault set: done=0, no state change, no mem_req. A WB/FILL already started completes regardless of fault.
- flush_write with a request:
  - Hit dirty -> WB, then valid=0, done=1 on the next IDLE cycle.
  - Hit clean or miss -> valid=0 (if hit), done=1 immediately.
  - Never fills.
- flush_all: one cycle, has priority over everything except reset. Clears all valid, dirty and LRU bits, and aborts WB/FILL to IDLE with mem_req=0 next cycle.
- read and write both nonzero is illegal; write wins.
- Reset mid-transaction: mem_req=0 next cycle; the partial line is discarded.
- mem_strobe is ignored in IDLE.
- NWAYS=1: LRU logic is absent and behaviour is direct-mapped.

Optional Feature:
DCACHE_STATS_EN: adds outputs hit_count[15:0] and miss_count[15:0]. Each is a saturating counter incremented once per completed non-flush request: hit if done in the first cycle, else miss. Both are cleared by reset and by flush_all. Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, read=11 paddr 0x000100 (byte 0x200). Expect mem_req=1, mem_we=0, mem_addr=0x00080. Supply nibbles 3,4,1,2,7,8,5,6 -> after the 8th strobe plus 1 cycle, done=1, rdata=0x1234. A following read 0x000101 gives rdata=0x5678.
2. After test 1, write=11 wdata=0xBEEF paddr 0x000101 -> done=1 same cycle, no mem_req. Read 0x000101 -> 0xBEEF. Read=10 at 0x000100 -> 0x0012.
3. Read 0x000108 (same set, new tag) fills way1 with no WB. Then read 0x000110: way0 (LRU, dirty) is written back with nibbles 3,4,1,2,E,F,B,E, mem_we=1, mem_addr=0x00080, then filled.
4. flush_write with read=11 on a dirty hit -> 8-beat WB, done=1. A subsequent read of the same address misses (mem_req=1, mem_we=0).
5. write=11 with fault=1 -> done=0, mem_req=0. Line contents and dirty bit unchanged over 10 cycles.
6. reset (or flush_all) asserted after 3 FILL beats -> mem_req=0 next cycle. Re-reading the address misses; with DCACHE_STATS_EN, hit_count=miss_count=0 after flush_all.
